chroni_bitmap_expander: RTL and testbench
=========================================

# chroni_bitmap_expander

Single-clock write-side pixel expander between the chroni character/bitmap generator and the line buffer RAM. It accepts one byte-wide write request per handshake and emits one pixel write per cycle. In direct mode the byte is written as-is. In bitmap mode each bit selects between an "on" and an "off" palette index, MSB first. It owns the `wr_busy` back-pressure seen by the font decode state machine.

## Interface
Parameters:
- `ADDR_W`, 11: pixel address width (line buffer holds two 640-pixel halves).
- `PIX_W`, 8: palette index width.

Ports:
- `sys_clk` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: request strobe; accepted when `wr_en && !wr_busy`.
- `wr_addr` in ADDR_W: address of the first pixel.
- `wr_data` in 8: pixel (direct) or bitmap byte.
- `wr_bitmap_on` in PIX_W: index written for a 1 bit.
- `wr_bitmap_off` in PIX_W: index written for a 0 bit.
- `wr_bitmap_bits` in 4: 0 = direct mode; 1–8 = number of bits expanded; 9–15 treated as 8.
- `wr_busy` out 1: request would not be accepted this cycle.
- `pix_wr_en` out 1: line buffer write strobe.
- `pix_wr_addr` out ADDR_W: line buffer write address.
- `pix_wr_data` out PIX_W: line buffer write data.

## Operation
- The FSM has two states: IDLE and EXPAND. Registers: `base_addr`, `byte`, `on`, `off`, `idx[2:0]`, `last[2:0]`.
- Accept in IDLE:
  - Direct mode: write `wr_data` to `wr_addr` once. Stay in IDLE.
  - Bitmap mode: latch all fields, set `idx=0` and `last=min(bits,8)-1`. Go to EXPAND, or stay IDLE if `last==0`, in which case the single pixel is emitted.
- EXPAND, each cycle:
  - Write pixel `byte[7-idx] ? on : off` to `base_addr+idx`.
  - When `idx==last`, go to IDLE. Otherwise increment `idx`.
- Address arithmetic is modulo 2^ADDR_W. There is no clamping at 640 or 1280; the caller owns the bounds.
- `wr_busy` is high in EXPAND while `idx != last`. It is low on the cycle the last pixel is registered, so a new request can be accepted then with no bubble.
- `wr_en` while `wr_busy` is ignored: no write and no state change. The caller must hold the request.
- Reset mid-operation: all state is cleared immediately and no further pixels are written. A partially expanded byte stays partial in RAM.

## Timing
- Outputs are registered. A request accepted at cycle T produces pixel i at T+1+i, for i = 0..last.
- Direct mode: one write at T+1. `wr_busy` never rises.
- Bitmap 8 bits: writes at T+1..T+8. `wr_busy` is high during T+1..T+7. The next accept is possible at T+8, with its first write at T+9.
- When not writing, `pix_wr_en` is 0, and `pix_wr_addr`/`pix_wr_data` hold their last values.
- Reset values: `pix_wr_en`=0, `pix_wr_addr`=0, `pix_wr_data`=0, `wr_busy`=0, state IDLE.

## Configuration
- `CHRONI_EXPAND_SKID_EN` defined:
  - Adds a one-deep pending slot, which accepts a request while EXPAND is in progress.
  - `wr_busy` equals pending-slot-valid.
  - On the cycle the active expansion emits its last pixel, the pending request promotes and its first pixel is emitted next cycle, so there is no bubble.
  - A direct-mode pending request also promotes in order. Ordering is strict FIFO.
- Undefined: no slot; `wr_busy` behaves as in Operation.

## Structure
- `chroni_pkg` holds:
  - the expander state enum (`EXP_IDLE`, `EXP_EXPAND`);
  - the `EXP_MAX_BITS`=8 constant;
  - a packed `chroni_wr_req_t` struct {addr, data, on, off, bits}.
- One sub-module, `chroni_wr_req_slot`, instantiated only under `CHRONI_EXPAND_SKID_EN`. It is a valid/ready register holding one `chroni_wr_req_t`.

## Test plan
- Direct: `bits=0`, `addr=0x005`, `data=0x3C` → exactly one write (0x005, 0x3C) at T+1; `wr_busy` stays 0.
- Bitmap 8: `addr=0x280`, `data=0xA5`, `on=0x0F`, `off=0x01`, back-to-back with a second byte `0xFF` at `0x288` → 16 consecutive writes 0x280..0x28F. Data: 0F,01,0F,01,01,0F,01,0F then eight 0F. No idle cycle between the two bytes.
- Clamp and wrap: `bits=12`, `addr=0x7FE`, `data=0x80` → 8 writes at 7FE, 7FF, 000..005 with data on then off×7.
- Ignored request: pulse `wr_en` with a different byte at T+3 of an 8-bit expansion → without skid, no extra writes and the original sequence is intact. With `CHRONI_EXPAND_SKID_EN`, the byte is written starting at T+9.
- Reset at T+4 of an 8-bit expansion → `pix_wr_en` drops immediately, no further writes, `wr_busy`=0. A new request after release works normally.
- Partial: `bits=3`, `data=0x60` → writes off, on, on at addr..addr+2. `wr_busy` is high for 2 cycles.

Source files
------------

// File: rtl/chroni_pkg.sv
// Shared types for the chroni write-side pixel expander.
package chroni_pkg;

  localparam int CHRONI_ADDR_W = 11;
  localparam int CHRONI_PIX_W  = 8;
  localparam int EXP_MAX_BITS  = 8;

  typedef enum logic {
    EXP_IDLE   = 1'b0,
    EXP_EXPAND = 1'b1
  } exp_state_e;

  typedef struct packed {
    logic [CHRONI_ADDR_W-1:0] addr;
    logic [7:0]               data;
    logic [CHRONI_PIX_W-1:0]  on;
    logic [CHRONI_PIX_W-1:0]  off;
    logic [3:0]               bits;
  } chroni_wr_req_t;

  // Index of the final pixel of a bitmap byte; bit counts above 8 saturate.
  // A bit count of 0 means direct mode and never reaches this function.
  function automatic logic [2:0] exp_last(input logic [3:0] bits);
    if (bits >= 4'(EXP_MAX_BITS)) return 3'd7;
    return 3'(bits - 4'd1);
  endfunction

endpackage

// File: rtl/chroni_wr_req_slot.sv
// One-deep valid/ready holding register for a pending write request.
// Only instantiated when CHRONI_EXPAND_SKID_EN is defined.
module chroni_wr_req_slot
  import chroni_pkg::*;
(
  input  logic           gclk,
  input  logic           grst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  chroni_wr_req_t in_req,
  output logic           out_vld,
  input  logic           out_rdy,
  output chroni_wr_req_t out_req
);

  logic           vld_d, vld_q;
  chroni_wr_req_t req_d, req_q;

  // Empty-only load keeps strict one-in/one-out ordering.
  always_comb begin
    vld_d = vld_q;
    req_d = req_q;
    if (vld_q && out_rdy) vld_d = 1'b0;
    if (in_vld && !vld_q) begin
      vld_d = 1'b1;
      req_d = in_req;
    end
  end

  // Slot registers.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      vld_q <= 1'b0;
      req_q <= '0;
    end else begin
      vld_q <= vld_d;
      req_q <= req_d;
    end
  end

  assign in_rdy  = !vld_q;
  assign out_vld = vld_q;
  assign out_req = req_q;

endmodule

// File: rtl/chroni_bitmap_expander.sv
// Byte-to-pixel write expander feeding the chroni line buffer.
// Direct mode writes one pixel; bitmap mode expands up to 8 bits MSB first
// into on/off palette indices, one pixel per cycle.
// Optional CHRONI_EXPAND_SKID_EN adds a one-deep pending request slot.
module chroni_bitmap_expander
  import chroni_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 8
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [PIX_W-1:0]  wr_bitmap_on,
  input  logic [PIX_W-1:0]  wr_bitmap_off,
  input  logic [3:0]        wr_bitmap_bits,
  output logic              wr_busy,
  output logic              pix_wr_en,
  output logic [ADDR_W-1:0] pix_wr_addr,
  output logic [PIX_W-1:0]  pix_wr_data
);

  exp_state_e        state_d, state_q;
  logic [ADDR_W-1:0] base_d, base_q;
  logic [7:0]        byte_d, byte_q;
  logic [PIX_W-1:0]  on_d, on_q, off_d, off_q;
  logic [2:0]        idx_d, idx_q, last_d, last_q;
  logic              pix_en_d, pix_en_q;
  logic [ADDR_W-1:0] pix_addr_d, pix_addr_q;
  logic [PIX_W-1:0]  pix_data_d, pix_data_q;

  chroni_wr_req_t in_req, src_req;
  logic           src_vld, core_rdy, accept;

  // Pack the request ports into the shared request struct.
  always_comb begin
    in_req      = '0;
    in_req.addr = CHRONI_ADDR_W'(wr_addr);
    in_req.data = wr_data;
    in_req.on   = CHRONI_PIX_W'(wr_bitmap_on);
    in_req.off  = CHRONI_PIX_W'(wr_bitmap_off);
    in_req.bits = wr_bitmap_bits;
  end

  // The core only starts a request from IDLE; pixel 0 is produced on accept.
  assign core_rdy = (state_q == EXP_IDLE);

`ifdef CHRONI_EXPAND_SKID_EN
  logic           slot_vld, slot_in_rdy;
  chroni_wr_req_t slot_req;

  // Requests arriving while the core is busy park here; a parked request
  // always wins over the port so ordering stays FIFO.
  chroni_wr_req_slot u_slot (
    .gclk    (sys_clk),
    .grst_n  (reset_n),
    .in_vld  (wr_en && !core_rdy),
    .in_rdy  (slot_in_rdy),
    .in_req  (in_req),
    .out_vld (slot_vld),
    .out_rdy (core_rdy),
    .out_req (slot_req)
  );

  assign src_vld = slot_vld | wr_en;
  assign src_req = slot_vld ? slot_req : in_req;
  assign wr_busy = !slot_in_rdy;
`else
  assign src_vld = wr_en;
  assign src_req = in_req;
  assign wr_busy = !core_rdy;
`endif

  assign accept = src_vld && core_rdy;

  // Next-state and registered pixel write computation.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    byte_d     = byte_q;
    on_d       = on_q;
    off_d      = off_q;
    idx_d      = idx_q;
    last_d     = last_q;
    pix_en_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    case (state_q)
      EXP_IDLE: begin
        if (accept) begin
          pix_en_d   = 1'b1;
          pix_addr_d = ADDR_W'(src_req.addr);
          if (src_req.bits == 4'd0) begin
            pix_data_d = PIX_W'(src_req.data);
          end else begin
            base_d     = ADDR_W'(src_req.addr);
            byte_d     = src_req.data;
            on_d       = PIX_W'(src_req.on);
            off_d      = PIX_W'(src_req.off);
            idx_d      = 3'd1;
            last_d     = exp_last(src_req.bits);
            pix_data_d = src_req.data[7] ? PIX_W'(src_req.on) : PIX_W'(src_req.off);
            if (last_d != 3'd0) state_d = EXP_EXPAND;
          end
        end
      end
      EXP_EXPAND: begin
        // idx_q is the pixel being emitted now; address wraps modulo 2^ADDR_W.
        pix_en_d   = 1'b1;
        pix_addr_d = base_q + ADDR_W'(idx_q);
        pix_data_d = byte_q[~idx_q] ? on_q : off_q;
        if (idx_q == last_q) state_d = EXP_IDLE;
        else                 idx_d   = idx_q + 3'd1;
      end
      default: state_d = EXP_IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial expansion.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EXP_IDLE;
      base_q     <= '0;
      byte_q     <= '0;
      on_q       <= '0;
      off_q      <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      pix_en_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      byte_q     <= byte_d;
      on_q       <= on_d;
      off_q      <= off_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      pix_en_q   <= pix_en_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
    end
  end

  assign pix_wr_en   = pix_en_q;
  assign pix_wr_addr = pix_addr_q;
  assign pix_wr_data = pix_data_q;

endmodule

// File: tb/tb_chroni_bitmap_expander.sv
// Scoreboard bench for chroni_bitmap_expander: each scenario pushes the
// expected (addr, data, cycle) writes; a negedge monitor pops and compares.
module tb_chroni_bitmap_expander;
  localparam int ADDR_W = 11;
  localparam int PIX_W  = 8;

  logic              sys_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic [PIX_W-1:0]  wr_bitmap_on = '0;
  logic [PIX_W-1:0]  wr_bitmap_off = '0;
  logic [3:0]        wr_bitmap_bits = '0;
  logic              wr_busy, pix_wr_en;
  logic [ADDR_W-1:0] pix_wr_addr;
  logic [PIX_W-1:0]  pix_wr_data;

  chroni_bitmap_expander #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_bitmap_on   (wr_bitmap_on),
    .wr_bitmap_off  (wr_bitmap_off),
    .wr_bitmap_bits (wr_bitmap_bits),
    .wr_busy        (wr_busy),
    .pix_wr_en      (pix_wr_en),
    .pix_wr_addr    (pix_wr_addr),
    .pix_wr_data    (pix_wr_data)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Every observed write must be the next expected one, at the expected cycle.
  always @(negedge sys_clk) begin
    if (pix_wr_en === 1'b1) begin
      ntests++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_write: got addr=%h data=%h cyc=%0d, required no write",
                 pix_wr_addr, pix_wr_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (pix_wr_addr !== mon_e.addr || pix_wr_data !== mon_e.data || cyc !== mon_e.cyc) begin
          nfail++;
          $display("FAIL pixel_write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                   pix_wr_addr, pix_wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Spec model: n = min(bits,8) pixels, MSB first, pixel i at t0+1+i.
  task automatic push_bitmap(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                             input logic [PIX_W-1:0] on, input logic [PIX_W-1:0] off,
                             input int bits, input int t0);
    exp_t e;
    int   n;
    n = (bits > 8) ? 8 : bits;
    for (int i = 0; i < n; i++) begin
      e.addr = a + ADDR_W'(i);
      e.data = d[7-i] ? on : off;
      e.cyc  = t0 + 1 + i;
      sb.push_back(e);
    end
  endtask

  task automatic push_direct(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int t0);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = t0 + 1;
    sb.push_back(e);
  endtask

  // Hold a request until it is accepted; t returns the accept cycle.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                       input logic [PIX_W-1:0] on, input logic [PIX_W-1:0] off,
                       input logic [3:0] bits, output int t);
    t = -1;
    wr_addr = a; wr_data = d; wr_bitmap_on = on; wr_bitmap_off = off;
    wr_bitmap_bits = bits; wr_en = 1'b1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      if (wr_busy === 1'b0) t = cyc;
      step(1);
    end
    wr_en = 1'b0;
    ntests++;
    if (t < 0) begin
      nfail++;
      $display("FAIL issue_accept: got no accept in 40 cycles, required accept");
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() > 0; k++) step(1);
    step(2);
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL %s_drain: got %0d writes missing, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic busy_count(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      if (wr_busy === 1'b1) cnt++;
      step(1);
    end
  endtask

  task automatic test_reset();
    step(3);
    ntests++;
    if ({pix_wr_en, wr_busy} !== 2'b00 || pix_wr_addr !== '0 || pix_wr_data !== '0) begin
      nfail++;
      $display("FAIL reset_values: got en=%b busy=%b addr=%h data=%h, required all 0",
               pix_wr_en, wr_busy, pix_wr_addr, pix_wr_data);
    end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_direct();
    int t, cnt;
    issue(11'h005, 8'h3C, 8'h00, 8'h00, 4'd0, t);
    push_direct(11'h005, 8'h3C, t);
    busy_count(4, cnt);
    ntests++;
    if (cnt !== 0) begin
      nfail++;
      $display("FAIL direct_busy: got %0d busy cycles, required 0", cnt);
    end
    drain("direct");
    ntests++;
    if (pix_wr_en !== 1'b0 || pix_wr_addr !== 11'h005 || pix_wr_data !== 8'h3C) begin
      nfail++;
      $display("FAIL idle_hold: got en=%b addr=%h data=%h, required en=0 addr=005 data=3c",
               pix_wr_en, pix_wr_addr, pix_wr_data);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    issue(11'h280, 8'hA5, 8'h0F, 8'h01, 4'd8, t1);
    push_bitmap(11'h280, 8'hA5, 8'h0F, 8'h01, 8, t1);
    issue(11'h288, 8'hFF, 8'h0F, 8'h01, 4'd8, t2);
    // Second byte must follow with no idle cycle, regardless of accept timing.
    push_bitmap(11'h288, 8'hFF, 8'h0F, 8'h01, 8, t1 + 8);
    drain("back_to_back");
  endtask

  task automatic test_wrap();
    int t;
    issue(11'h7FE, 8'h80, 8'h55, 8'hAA, 4'd12, t);
    push_bitmap(11'h7FE, 8'h80, 8'h55, 8'hAA, 12, t);
    drain("wrap");
  endtask

  task automatic test_ignored();
    int t;
    issue(11'h100, 8'h96, 8'h22, 8'h33, 4'd8, t);
    push_bitmap(11'h100, 8'h96, 8'h22, 8'h33, 8, t);
    step(2);
    wr_addr = 11'h300; wr_data = 8'hC0; wr_bitmap_on = 8'h44; wr_bitmap_off = 8'h55;
    wr_bitmap_bits = 4'd2; wr_en = 1'b1;
    ntests++;
`ifdef CHRONI_EXPAND_SKID_EN
    if (wr_busy !== 1'b0) begin
      nfail++;
      $display("FAIL ignored_busy: got %b, required 0", wr_busy);
    end
    push_bitmap(11'h300, 8'hC0, 8'h44, 8'h55, 2, t + 8);
`else
    if (wr_busy !== 1'b1) begin
      nfail++;
      $display("FAIL ignored_busy: got %b, required 1", wr_busy);
    end
`endif
    step(1);
    wr_en = 1'b0;
    drain("ignored");
  endtask

  task automatic test_partial();
    int t, cnt;
    issue(11'h040, 8'h60, 8'h7A, 8'h0B, 4'd3, t);
    push_bitmap(11'h040, 8'h60, 8'h7A, 8'h0B, 3, t);
    busy_count(5, cnt);
    ntests++;
`ifdef CHRONI_EXPAND_SKID_EN
    if (cnt !== 0) begin
      nfail++;
      $display("FAIL partial_busy: got %0d busy cycles, required 0", cnt);
    end
`else
    if (cnt !== 2) begin
      nfail++;
      $display("FAIL partial_busy: got %0d busy cycles, required 2", cnt);
    end
`endif
    drain("partial");
  endtask

  task automatic test_reset_mid();
    int t;
    issue(11'h200, 8'hF0, 8'h11, 8'h22, 4'd8, t);
    push_bitmap(11'h200, 8'hF0, 8'h11, 8'h22, 3, t);
    step(3);
    reset_n = 1'b0;
    #1;
    ntests++;
    if (pix_wr_en !== 1'b0 || wr_busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mid: got en=%b busy=%b, required en=0 busy=0", pix_wr_en, wr_busy);
    end
    step(2);
    reset_n = 1'b1;
    step(2);
    drain("reset_mid");
    issue(11'h010, 8'h81, 8'h66, 8'h77, 4'd8, t);
    push_bitmap(11'h010, 8'h81, 8'h66, 8'h77, 8, t);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_direct();
    test_back_to_back();
    test_wrap();
    test_ignored();
    test_partial();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
